// File: rtl/sl_bus_arbiter_pkg.sv
// ice_bus_pkg: shared types and constants for the ICE slave-bus arbiter.
// Holds the FSM encoding, frame length ceiling, default requester count
// and a saturating byte-count helper.
package ice_bus_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_GRANT = ST_GRANT,
        S_GAP   = ST_GAP
    } arb_state_e;

    localparam logic [7:0] FRAME_LEN_MAX   = 8'd255;
    localparam int         DEFAULT_NUM_DEV = 7;

    function automatic logic [7:0] sat_inc(
        input logic [7:0] v,
        input logic       inc
    );
        if (inc && (v != FRAME_LEN_MAX)) begin
            return v + 8'd1;
        end
        return v;
    endfunction

endpackage

// File: rtl/sl_bus_arbiter_if.sv
// sl_bus_arbiter_if: request/grant bundle between slave blocks and arbiter.
// master: arbiter side (drives grant, status); slave: requester side.
interface sl_bus_arbiter_if
    import ice_bus_pkg::*;
#(
    parameter int NUM_DEV = DEFAULT_NUM_DEV
);

    logic [NUM_DEV-1:0] sl_arb_request;
    logic               arb_enable;
    logic               sl_data_latch;
    logic [NUM_DEV-1:0] sl_arb_grant;
    logic               grant_valid;
    logic [3:0]         grant_idx;
    logic               frame_done;
    logic [7:0]         frame_len;
    logic               timeout_evt;

    modport master (
        input  sl_arb_request,
        input  arb_enable,
        input  sl_data_latch,
        output sl_arb_grant,
        output grant_valid,
        output grant_idx,
        output frame_done,
        output frame_len,
        output timeout_evt
    );

    modport slave (
        output sl_arb_request,
        output arb_enable,
        output sl_data_latch,
        input  sl_arb_grant,
        input  grant_valid,
        input  grant_idx,
        input  frame_done,
        input  frame_len,
        input  timeout_evt
    );

endinterface

// File: rtl/sl_bus_arbiter_rr_pick.sv
// sl_bus_arbiter_rr_pick: combinational round-robin picker.
// Ports: req (requests), ptr (first index to try) -> any, idx, onehot.
module sl_bus_arbiter_rr_pick
    import ice_bus_pkg::*;
#(
    parameter int NUM_DEV = DEFAULT_NUM_DEV
) (
    input  logic [NUM_DEV-1:0] req,
    input  logic [3:0]         ptr,
    output logic               any,
    output logic [3:0]         idx,
    output logic [NUM_DEV-1:0] onehot
);

    logic [NUM_DEV-1:0] rot;
    logic [3:0]         pos;
    logic [4:0]         sum;

    always_comb begin
        // Bit 0 of rot is device ptr; ptr is always below NUM_DEV.
        rot = NUM_DEV'({req, req} >> ptr);
        any = 1'b0;
        pos = '0;
        for (int k = NUM_DEV - 1; k >= 0; k--) begin
            if (rot[k]) begin
                any = 1'b1;
                pos = 4'(k);
            end
        end
        sum = 5'(pos) + 5'(ptr);
        if (sum >= 5'(NUM_DEV)) begin
            sum = sum - 5'(NUM_DEV);
        end
        idx = any ? sum[3:0] : 4'd0;
        onehot = '0;
        for (int k = 0; k < NUM_DEV; k++) begin
            onehot[k] = any && (idx == 4'(k));
        end
    end

endmodule

// File: rtl/sl_bus_arbiter.sv
// sl_bus_arbiter: round-robin owner of the shared slave output bus.
// Ports: clk, rst (sync, active-high), bus (sl_bus_arbiter_if.master).
// Grant held for a whole frame; one GAP cycle after each release.
// Optional watchdog revoke: define SL_ARB_WATCHDOG_EN.
module sl_bus_arbiter
    import ice_bus_pkg::*;
#(
    parameter int NUM_DEV     = DEFAULT_NUM_DEV,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic             clk,
    input  logic             rst,
    sl_bus_arbiter_if.master bus
);

    arb_state_e         state_q, state_d;
    logic [NUM_DEV-1:0] grant_q, grant_d;
    logic               valid_q, valid_d;
    logic [3:0]         idx_q, idx_d;
    logic [3:0]         ptr_q, ptr_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [7:0]         len_q, len_d;
    logic               done_q, done_d;

    logic [NUM_DEV-1:0] eligible;
    logic               pick_any;
    logic [3:0]         pick_idx;
    logic [NUM_DEV-1:0] pick_onehot;
    logic               owner_req;
    logic [7:0]         cnt_inc;
    logic               wd_expire;

    // grant_q is one-hot, so this selects the owner's request.
    assign owner_req = |(bus.sl_arb_request & grant_q);
    assign cnt_inc   = sat_inc(cnt_q, bus.sl_data_latch & valid_q);

`ifdef SL_ARB_WATCHDOG_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);

    logic [IDLE_W-1:0]  idle_q, idle_d;
    logic [NUM_DEV-1:0] mask_q, mask_d;
    logic               to_q;

    assign eligible  = bus.sl_arb_request & ~mask_q;
    // A simultaneous owner drop wins: it is a normal release.
    assign wd_expire = (state_q == S_GRANT) && owner_req &&
                       !bus.sl_data_latch &&
                       (idle_q == IDLE_W'(TIMEOUT_CYC - 1));

    always_comb begin
        idle_d = '0;
        if (state_q == S_GRANT) begin
            idle_d = bus.sl_data_latch ? '0 : idle_q + IDLE_W'(1);
        end
        // Mask lifts once the revoked device drops its request.
        mask_d = mask_q & bus.sl_arb_request;
        if (wd_expire) begin
            mask_d = mask_d | grant_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idle_q <= '0;
            mask_q <= '0;
            to_q   <= 1'b0;
        end else begin
            idle_q <= idle_d;
            mask_q <= mask_d;
            to_q   <= wd_expire;
        end
    end

    assign bus.timeout_evt = to_q;
`else
    assign eligible        = bus.sl_arb_request;
    assign wd_expire       = 1'b0;
    assign bus.timeout_evt = 1'b0;
`endif

    sl_bus_arbiter_rr_pick #(
        .NUM_DEV (NUM_DEV)
    ) u_pick (
        .req    (eligible),
        .ptr    (ptr_q),
        .any    (pick_any),
        .idx    (pick_idx),
        .onehot (pick_onehot)
    );

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        valid_d = valid_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.arb_enable && pick_any) begin
                    state_d = S_GRANT;
                    grant_d = pick_onehot;
                    valid_d = 1'b1;
                    idx_d   = pick_idx;
                    cnt_d   = '0;
                    ptr_d   = (pick_idx == 4'(NUM_DEV - 1)) ?
                              4'd0 : pick_idx + 4'd1;
                end
            end
            S_GRANT: begin
                cnt_d = cnt_inc;
                if (!owner_req || wd_expire) begin
                    state_d = S_GAP;
                    grant_d = '0;
                    valid_d = 1'b0;
                    idx_d   = '0;
                    done_d  = 1'b1;
                    len_d   = cnt_inc;
                    cnt_d   = '0;
                end
            end
            S_GAP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            valid_q <= 1'b0;
            idx_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            valid_q <= valid_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            done_q  <= done_d;
        end
    end

    assign bus.sl_arb_grant = grant_q;
    assign bus.grant_valid  = valid_q;
    assign bus.grant_idx    = idx_q;
    assign bus.frame_done   = done_q;
    assign bus.frame_len    = len_q;

endmodule

// File: tb/tb_sl_bus_arbiter.sv
// tb_sl_bus_arbiter: directed scenarios plus a randomized run
// against a frame-level reference model of the arbiter.
module tb_sl_bus_arbiter;
    import ice_bus_pkg::*;

    localparam int N  = 7;
    localparam int TO = 16;
`ifdef SL_ARB_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    sl_bus_arbiter_if #(.NUM_DEV(N)) bus ();

    sl_bus_arbiter #(
        .NUM_DEV     (N),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference model: current owner (-1 = none), phase 0 idle,
    // 1 owned, 2 gap; expected registered outputs.
    int         m_phase = 0;
    int         m_owner = -1;
    int         m_ptr   = 0;
    int         m_cnt   = 0;
    int         m_len   = 0;
    int         m_idle  = 0;
    bit         m_done  = 0;
    bit         m_to    = 0;
    logic [N-1:0] m_mask = '0;

    function automatic bit bit_of(input logic [N-1:0] v, input int i);
        return ((v >> i) & N'(1)) != '0;
    endfunction

    task automatic model_edge(input logic x, input logic [N-1:0] r,
                              input logic e, input logic l);
        logic [N-1:0] elig;
        int w;
        m_done = 0;
        m_to   = 0;
        if (x) begin
            m_phase = 0; m_owner = -1; m_ptr = 0; m_cnt = 0;
            m_len = 0; m_idle = 0; m_mask = '0;
            return;
        end
        elig   = r & ~m_mask;
        m_mask = m_mask & r;
        case (m_phase)
            0: begin
                if (e && elig != '0) begin
                    w = -1;
                    for (int k = 0; k < N; k++) begin
                        if (w < 0 && bit_of(elig, (m_ptr + k) % N)) begin
                            w = (m_ptr + k) % N;
                        end
                    end
                    m_owner = w;
                    m_ptr   = (w + 1) % N;
                    m_phase = 1;
                    m_cnt   = 0;
                    m_idle  = 0;
                end
            end
            1: begin
                if (l && m_cnt < 255) m_cnt++;
                if (!bit_of(r, m_owner)) begin
                    m_done = 1; m_len = m_cnt; m_owner = -1;
                    m_phase = 2; m_cnt = 0;
                end else if (WD && !l && m_idle == TO - 1) begin
                    m_done = 1; m_to = 1; m_len = m_cnt;
                    m_mask = m_mask | (N'(1) << m_owner);
                    m_owner = -1; m_phase = 2; m_cnt = 0;
                end else begin
                    m_idle = l ? 0 : m_idle + 1;
                end
            end
            default: m_phase = 0;
        endcase
    endtask

    // One clock: inputs are sampled at the edge, outputs checked at +1.
    task automatic tick();
        logic [N-1:0] r;
        logic e, l, x;
        r = bus.sl_arb_request;
        e = bus.arb_enable;
        l = bus.sl_data_latch;
        x = rst;
        @(posedge clk);
        model_edge(x, r, e, l);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.sl_arb_request = '0;
        bus.arb_enable = 1'b0;
        bus.sl_data_latch = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.sl_arb_request = '1;
        bus.arb_enable = 1'b1;
        bus.sl_data_latch = 1'b1;
        tick();
        checks++;
        if (bus.sl_arb_grant !== '0 || bus.grant_valid !== 1'b0 ||
            bus.grant_idx !== 4'd0) begin
            failures++;
            $display("FAIL reset_grant got=%b/%b/%0d exp=0/0/0",
                     bus.sl_arb_grant, bus.grant_valid, bus.grant_idx);
        end
        checks++;
        if (bus.frame_done !== 1'b0 || bus.frame_len !== 8'd0 ||
            bus.timeout_evt !== 1'b0) begin
            failures++;
            $display("FAIL reset_status got=%b/%0d/%b exp=0/0/0",
                     bus.frame_done, bus.frame_len, bus.timeout_evt);
        end
        rst = 1'b0;
        bus.sl_arb_request = '0;
        bus.arb_enable = 1'b0;
        bus.sl_data_latch = 1'b0;
        tick();
    endtask

    task automatic test_single();
        do_reset();
        bus.sl_arb_request = 7'b0000100;
        bus.arb_enable = 1'b1;
        tick();
        checks++;
        if (bus.sl_arb_grant !== 7'b0000100 || bus.grant_idx !== 4'd2) begin
            failures++;
            $display("FAIL single_grant got=%b idx=%0d exp=0000100 idx=2",
                     bus.sl_arb_grant, bus.grant_idx);
        end
        bus.sl_data_latch = 1'b1;
        repeat (5) tick();
        bus.sl_data_latch = 1'b0;
        bus.sl_arb_request = '0;
        tick();
        checks++;
        if (bus.frame_done !== 1'b1 || bus.frame_len !== 8'd5) begin
            failures++;
            $display("FAIL single_done got=%b len=%0d exp=1 len=5",
                     bus.frame_done, bus.frame_len);
        end
        checks++;
        if (bus.grant_valid !== 1'b0 || bus.sl_arb_grant !== '0) begin
            failures++;
            $display("FAIL single_gap got=%b/%b exp=0/0",
                     bus.grant_valid, bus.sl_arb_grant);
        end
        tick();
        checks++;
        if (bus.frame_done !== 1'b0) begin
            failures++;
            $display("FAIL single_pulse got=%b exp=0", bus.frame_done);
        end
    endtask

    task automatic test_rotation();
        do_reset();
        bus.sl_arb_request = '1;
        bus.arb_enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (bus.grant_valid !== 1'b1 || bus.grant_idx !== 4'(i % N)) begin
                failures++;
                $display("FAIL rot_idx[%0d] got=%0d exp=%0d",
                         i, bus.grant_idx, i % N);
            end
            bus.sl_data_latch = 1'b1;
            tick();
            bus.sl_data_latch = 1'b0;
            bus.sl_arb_request = ~(N'(1) << (i % N));
            tick();
            checks++;
            if (bus.frame_done !== 1'b1 || bus.frame_len !== 8'd1) begin
                failures++;
                $display("FAIL rot_len[%0d] got=%b/%0d exp=1/1",
                         i, bus.frame_done, bus.frame_len);
            end
            bus.sl_arb_request = '1;
            tick();
        end
        bus.sl_arb_request = '0;
        tick();
    endtask

    task automatic test_no_preempt();
        do_reset();
        bus.sl_arb_request = 7'b0100000;
        bus.arb_enable = 1'b1;
        tick();
        bus.sl_arb_request = 7'b0100001;
        repeat (3) tick();
        checks++;
        if (bus.sl_arb_grant !== 7'b0100000 || bus.grant_idx !== 4'd5) begin
            failures++;
            $display("FAIL preempt_hold got=%b idx=%0d exp=0100000 idx=5",
                     bus.sl_arb_grant, bus.grant_idx);
        end
        bus.sl_arb_request = 7'b0000001;
        tick();
        checks++;
        if (bus.frame_done !== 1'b1 || bus.grant_valid !== 1'b0) begin
            failures++;
            $display("FAIL preempt_rel got=%b/%b exp=1/0",
                     bus.frame_done, bus.grant_valid);
        end
        tick();
        checks++;
        if (bus.grant_valid !== 1'b0) begin
            failures++;
            $display("FAIL preempt_idle got=%b exp=0", bus.grant_valid);
        end
        tick();
        checks++;
        if (bus.sl_arb_grant !== 7'b0000001 || bus.grant_idx !== 4'd0) begin
            failures++;
            $display("FAIL preempt_next got=%b idx=%0d exp=0000001 idx=0",
                     bus.sl_arb_grant, bus.grant_idx);
        end
        bus.sl_arb_request = '0;
        repeat (3) tick();
    endtask

    task automatic test_enable_gate();
        do_reset();
        bus.arb_enable = 1'b0;
        bus.sl_arb_request = 7'b0001000;
        repeat (4) tick();
        checks++;
        if (bus.grant_valid !== 1'b0) begin
            failures++;
            $display("FAIL enable_off got=%b exp=0", bus.grant_valid);
        end
        bus.arb_enable = 1'b1;
        tick();
        checks++;
        if (bus.grant_valid !== 1'b1 || bus.grant_idx !== 4'd3) begin
            failures++;
            $display("FAIL enable_on got=%b idx=%0d exp=1 idx=3",
                     bus.grant_valid, bus.grant_idx);
        end
        bus.arb_enable = 1'b0;
        repeat (2) tick();
        checks++;
        if (bus.grant_valid !== 1'b1) begin
            failures++;
            $display("FAIL enable_hold got=%b exp=1", bus.grant_valid);
        end
        bus.sl_arb_request = '0;
        repeat (3) tick();
    endtask

    task automatic test_saturation();
        do_reset();
        bus.sl_arb_request = 7'b0000010;
        bus.arb_enable = 1'b1;
        tick();
        bus.sl_data_latch = 1'b1;
        repeat (300) tick();
        bus.sl_data_latch = 1'b0;
        bus.sl_arb_request = '0;
        tick();
        checks++;
        if (bus.frame_done !== 1'b1 || bus.frame_len !== 8'd255) begin
            failures++;
            $display("FAIL sat_len got=%b/%0d exp=1/255",
                     bus.frame_done, bus.frame_len);
        end
    endtask

    task automatic test_zero_len();
        bus.arb_enable = 1'b1;
        bus.sl_data_latch = 1'b1;
        repeat (3) tick();
        bus.sl_arb_request = 7'b0010000;
        tick();
        checks++;
        if (bus.grant_idx !== 4'd4 || bus.grant_valid !== 1'b1) begin
            failures++;
            $display("FAIL zero_grant got=%0d/%b exp=4/1",
                     bus.grant_idx, bus.grant_valid);
        end
        bus.sl_arb_request = '0;
        bus.sl_data_latch = 1'b0;
        tick();
        checks++;
        if (bus.frame_done !== 1'b1 || bus.frame_len !== 8'd0) begin
            failures++;
            $display("FAIL zero_len got=%b/%0d exp=1/0",
                     bus.frame_done, bus.frame_len);
        end
        repeat (2) tick();
    endtask

    task automatic test_reset_mid();
        bus.sl_arb_request = 7'b0001000;
        bus.arb_enable = 1'b1;
        tick();
        checks++;
        if (bus.grant_idx !== 4'd3) begin
            failures++;
            $display("FAIL rmid_grant got=%0d exp=3", bus.grant_idx);
        end
        bus.sl_data_latch = 1'b1;
        repeat (2) tick();
        bus.sl_data_latch = 1'b0;
        rst = 1'b1;
        tick();
        checks++;
        if (bus.sl_arb_grant !== '0 || bus.grant_valid !== 1'b0 ||
            bus.frame_done !== 1'b0 || bus.frame_len !== 8'd0) begin
            failures++;
            $display("FAIL rmid_clear got=%b/%b/%b/%0d exp=0/0/0/0",
                     bus.sl_arb_grant, bus.grant_valid,
                     bus.frame_done, bus.frame_len);
        end
        rst = 1'b0;
        bus.sl_arb_request = '1;
        tick();
        checks++;
        if (bus.grant_idx !== 4'd0 || bus.grant_valid !== 1'b1) begin
            failures++;
            $display("FAIL rmid_ptr got=%0d/%b exp=0/1",
                     bus.grant_idx, bus.grant_valid);
        end
        bus.sl_arb_request = '0;
        repeat (3) tick();
    endtask

    task automatic test_watchdog();
        bit bad;
        do_reset();
        bus.sl_arb_request = 7'b0000010;
        bus.arb_enable = 1'b1;
        tick();
        bad = 0;
`ifdef SL_ARB_WATCHDOG_EN
        repeat (TO - 1) begin
            tick();
            if (bus.timeout_evt !== 1'b0 || bus.grant_valid !== 1'b1) bad = 1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL wd_early got=%b/%b exp=0/1",
                     bus.timeout_evt, bus.grant_valid);
        end
        tick();
        checks++;
        if (bus.timeout_evt !== 1'b1 || bus.frame_done !== 1'b1 ||
            bus.grant_valid !== 1'b0) begin
            failures++;
            $display("FAIL wd_fire got=%b/%b/%b exp=1/1/0",
                     bus.timeout_evt, bus.frame_done, bus.grant_valid);
        end
        bad = 0;
        repeat (10) begin
            tick();
            if (bus.grant_valid !== 1'b0) bad = 1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL wd_mask got=%b exp=0", bus.grant_valid);
        end
        bus.sl_arb_request = '0;
        tick();
        bus.sl_arb_request = 7'b0000010;
        tick();
        checks++;
        if (bus.grant_valid !== 1'b1 || bus.grant_idx !== 4'd1) begin
            failures++;
            $display("FAIL wd_unmask got=%b/%0d exp=1/1",
                     bus.grant_valid, bus.grant_idx);
        end
`else
        repeat (1000) begin
            tick();
            if (bus.timeout_evt !== 1'b0 || bus.grant_valid !== 1'b1) bad = 1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL wd_off got=%b/%b exp=0/1",
                     bus.timeout_evt, bus.grant_valid);
        end
`endif
        bus.sl_arb_request = '0;
        repeat (3) tick();
    endtask

    task automatic test_random();
        logic [N-1:0] eg;
        int errs;
        do_reset();
        errs = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 7) == 0) begin
                    bus.sl_arb_request = bus.sl_arb_request ^ (N'(1) << i);
                end
            end
            bus.arb_enable = ($urandom_range(0, 3) != 0);
            bus.sl_data_latch = ($urandom_range(0, 2) == 0);
            tick();
            eg = (m_owner < 0) ? '0 : (N'(1) << m_owner);
            checks++;
            if (bus.sl_arb_grant !== eg ||
                bus.grant_valid !== (m_owner >= 0) ||
                bus.grant_idx !== 4'((m_owner < 0) ? 0 : m_owner) ||
                bus.frame_done !== m_done ||
                bus.frame_len !== 8'(m_len) ||
                bus.timeout_evt !== m_to) begin
                failures++;
                errs++;
                if (errs <= 10) begin
                    $display("FAIL rand[%0d] got=%b/%0d/%b/%0d/%b exp=%b/%0d/%b/%0d/%b",
                             c, bus.sl_arb_grant, bus.grant_idx,
                             bus.frame_done, bus.frame_len, bus.timeout_evt,
                             eg, (m_owner < 0) ? 0 : m_owner,
                             m_done, m_len, m_to);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.sl_arb_request = '0;
        bus.arb_enable = 1'b0;
        bus.sl_data_latch = 1'b0;
        test_reset();
        test_single();
        test_rotation();
        test_no_preempt();
        test_enable_gate();
        test_saturation();
        test_zero_len();
        test_reset_mid();
        test_watchdog();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
